// File: rtl/operand_issue_stage.sv
// ID->EX operand stage: GPR file with WB write-through, rt/immediate select, ID/EX register.
// Optional macro FORWARD_EX_EN adds EX->EX forwarding of alu_result into the operand reads.

// One GPR read port. Reg 0 reads as zero, and a same-cycle WB write to src wins over the array.
module operand_issue_read #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] src,
  input  logic [DATA_W-1:0] gpr_val,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] val
);
  always_comb begin
    val = gpr_val;
    if (src == '0)                      val = '0;
    else if (wb_en && (wb_addr == src)) val = wb_data;
  end
endmodule

module operand_issue_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [15:0]       imm16,
  input  logic              use_imm,
  input  logic              sign_ext,
  input  logic [2:0]        alu_op,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic              reg_write,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] alu_result,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [2:0]        ex_alu_ctr,
  output logic [ADDR_W-1:0] ex_dst,
  output logic              ex_reg_write
);
  localparam int NREG    = 1 << ADDR_W;
  localparam int NUM_SRC = 2;  // port 0 = rs (A), port 1 = rt (B)

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        alu_ctr;
    logic [ADDR_W-1:0] dst;
  } idex_t;

  logic [NREG-1:0][DATA_W-1:0]    gpr;
  logic [NUM_SRC-1:0][ADDR_W-1:0] src_addr;
  logic [NUM_SRC-1:0][DATA_W-1:0] rd_val;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_val;
  logic [DATA_W-1:0]              imm_ext;
  idex_t                          ex_d, ex_q;
  logic                           vld_q, rw_q;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         gpr <= '0;
    else if (wb_en && (wb_addr != '0)) gpr[wb_addr] <= wb_data;
  end

  assign src_addr = {rt_addr, rs_addr};

  generate
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      operand_issue_read #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
        .src     (src_addr[g]),
        .gpr_val (gpr[src_addr[g]]),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .val     (rd_val[g])
      );
`ifdef FORWARD_EX_EN
      // The instruction sitting in ID/EX is newer than anything in WB, so its result wins.
      assign src_val[g] = (vld_q && rw_q && (ex_q.dst != '0) && (ex_q.dst == src_addr[g]))
                          ? alu_result : rd_val[g];
`else
      assign src_val[g] = rd_val[g];
`endif
    end
  endgenerate

`ifndef FORWARD_EX_EN
  logic unused_alu_result;
  assign unused_alu_result = ^alu_result;
`endif

  assign imm_ext = sign_ext ? {{(DATA_W-16){imm16[15]}}, imm16} : {{(DATA_W-16){1'b0}}, imm16};

  always_comb begin
    ex_d         = '0;
    ex_d.a       = src_val[0];
    ex_d.b       = use_imm ? imm_ext : src_val[1];
    ex_d.alu_ctr = alu_op;
    ex_d.dst     = dst_addr;
  end

  // flush > stall > load; a flush leaves the data fields as they were.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      rw_q  <= 1'b0;
      ex_q  <= '{a: '0, b: '0, alu_ctr: 3'b010, dst: '0};
    end else if (flush) begin
      vld_q <= 1'b0;
      rw_q  <= 1'b0;
    end else if (!stall) begin
      vld_q <= in_valid;
      rw_q  <= reg_write & in_valid;
      ex_q  <= ex_d;
    end
  end

  assign ex_valid     = vld_q;
  assign ex_reg_write = rw_q;
  assign ex_a         = ex_q.a;
  assign ex_b         = ex_q.b;
  assign ex_alu_ctr   = ex_q.alu_ctr;
  assign ex_dst       = ex_q.dst;
endmodule

// File: tb/tb_operand_issue_stage.sv
// Directed bench for operand_issue_stage: expected ID/EX contents are queued when a step is
// driven and compared one edge later (or immediately for async reset).
module tb_operand_issue_stage;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid, stall, flush, use_imm, sign_ext, reg_write, wb_en;
  logic [ADDR_W-1:0] rs_addr, rt_addr, dst_addr, wb_addr;
  logic [15:0]       imm16;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] wb_data, alu_result;
  logic              ex_valid, ex_reg_write;
  logic [DATA_W-1:0] ex_a, ex_b;
  logic [2:0]        ex_alu_ctr;
  logic [ADDR_W-1:0] ex_dst;

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctr;
    logic [4:0]  dst;
    logic        rw;
    bit          data;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic [31:0] fwd_val;

  always #5 clk = ~clk;

  operand_issue_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .imm16(imm16), .use_imm(use_imm),
    .sign_ext(sign_ext), .alu_op(alu_op), .dst_addr(dst_addr), .reg_write(reg_write),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .alu_result(alu_result),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_ctr(ex_alu_ctr),
    .ex_dst(ex_dst), .ex_reg_write(ex_reg_write)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] ctr, input logic [4:0] dst, input logic rw, input bit data);
    exp_t e;
    e.v = v; e.a = a; e.b = b; e.ctr = ctr; e.dst = dst; e.rw = rw; e.data = data;
    sb.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      tests++; fails++;
      $error("FAIL %s: observed empty scoreboard expected one entry", tag);
      return;
    end
    e = sb.pop_front();
    cmp({tag, ".valid"}, {31'b0, ex_valid}, {31'b0, e.v});
    cmp({tag, ".rw"}, {31'b0, ex_reg_write}, {31'b0, e.rw});
    if (e.data) begin
      cmp({tag, ".a"}, ex_a, e.a);
      cmp({tag, ".b"}, ex_b, e.b);
      cmp({tag, ".ctr"}, {29'b0, ex_alu_ctr}, {29'b0, e.ctr});
      cmp({tag, ".dst"}, {27'b0, ex_dst}, {27'b0, e.dst});
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk); #1;
    check(tag);
  endtask

  task automatic idle();
    in_valid = 0; stall = 0; flush = 0; use_imm = 0; sign_ext = 0; reg_write = 0;
    rs_addr = 0; rt_addr = 0; dst_addr = 0; imm16 = 0; alu_op = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0; alu_result = 0;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    push(0, 0, 0, 3'b010, 0, 0, 1); check("reset_init");
    rst_n = 1;

    // write r3, then read it back
    idle(); wb_en = 1; wb_addr = 3; wb_data = 32'h1234_5678; alu_op = 3'b010;
    push(0, 0, 0, 3'b010, 0, 0, 1); cycle("wb_r3");
    idle(); rs_addr = 3; alu_op = 3'b010; in_valid = 1; dst_addr = 9; reg_write = 1;
    push(1, 32'h1234_5678, 0, 3'b010, 9, 1, 1); cycle("rd_r3");

    // same-cycle write-through, then write to r0 is discarded
    idle(); wb_en = 1; wb_addr = 7; wb_data = 32'hDEAD_BEEF; rs_addr = 7; rt_addr = 3;
    alu_op = 3'b110; in_valid = 1; dst_addr = 2;
    push(1, 32'hDEAD_BEEF, 32'h1234_5678, 3'b110, 2, 0, 1); cycle("wt_r7");
    idle(); wb_en = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF; rt_addr = 7;
    alu_op = 3'b001; in_valid = 1; reg_write = 1;
    push(1, 0, 32'hDEAD_BEEF, 3'b001, 0, 1, 1); cycle("wt_r0");
    idle(); alu_op = 3'b011; in_valid = 1; dst_addr = 1; reg_write = 1;
    push(1, 0, 0, 3'b011, 1, 1, 1); cycle("r0_after");

    // immediate extension
    idle(); rs_addr = 3; use_imm = 1; imm16 = 16'h8001; sign_ext = 1; alu_op = 3'b010;
    in_valid = 1; dst_addr = 4; reg_write = 1;
    push(1, 32'h1234_5678, 32'hFFFF_8001, 3'b010, 4, 1, 1); cycle("imm_sx");
    idle(); rs_addr = 3; rt_addr = 7; use_imm = 1; imm16 = 16'h8001; alu_op = 3'b010;
    in_valid = 1; dst_addr = 6; reg_write = 1;
    push(1, 32'h1234_5678, 32'h0000_8001, 3'b010, 6, 1, 1); cycle("imm_zx");
    idle(); rs_addr = 3; use_imm = 1; imm16 = 16'h7FFF; sign_ext = 1; alu_op = 3'b010;
    dst_addr = 6; reg_write = 1;
    push(0, 32'h1234_5678, 32'h0000_7FFF, 3'b010, 6, 0, 1); cycle("inv_rw");

    // stall holds, GPR still written; flush beats stall
    idle(); rs_addr = 7; rt_addr = 3; alu_op = 3'b101; in_valid = 1; dst_addr = 12; reg_write = 1;
    push(1, 32'hDEAD_BEEF, 32'h1234_5678, 3'b101, 12, 1, 1); cycle("pre_stall");
    for (int k = 0; k < 3; k++) begin
      idle(); stall = 1; in_valid = 1; rs_addr = 3; rt_addr = 7; dst_addr = 1;
      wb_en = 1; wb_addr = 5; wb_data = 32'h0000_0055;
      push(1, 32'hDEAD_BEEF, 32'h1234_5678, 3'b101, 12, 1, 1); cycle("stall");
    end
    idle(); stall = 1; flush = 1; in_valid = 1; reg_write = 1;
    push(0, 0, 0, 0, 0, 0, 0); cycle("stall_flush");
    idle(); flush = 1; in_valid = 1; reg_write = 1; rs_addr = 3;
    push(0, 0, 0, 0, 0, 0, 0); cycle("flush");
    idle(); rs_addr = 5; alu_op = 3'b100; in_valid = 1; dst_addr = 3; reg_write = 1;
    push(1, 32'h0000_0055, 0, 3'b100, 3, 1, 1); cycle("wr_in_stall");

    // EX->EX forwarding (r4 never written)
    idle(); alu_op = 3'b010; in_valid = 1; dst_addr = 4; reg_write = 1;
    push(1, 0, 0, 3'b010, 4, 1, 1); cycle("fwd_prod");
`ifdef FORWARD_EX_EN
    fwd_val = 32'h0000_00AA;
`else
    fwd_val = 32'h0;
`endif
    idle(); rs_addr = 4; rt_addr = 4; alu_result = 32'h0000_00AA; alu_op = 3'b010;
    in_valid = 1; dst_addr = 8;
    push(1, fwd_val, fwd_val, 3'b010, 8, 0, 1); cycle("fwd");
    idle(); rs_addr = 8; alu_result = 32'h0000_00BB; in_valid = 1;
    push(1, 0, 0, 3'b000, 0, 0, 1); cycle("nofwd_rw0");

    // async reset in the middle of a stall/flush
    idle(); stall = 1; flush = 1; in_valid = 1;
    rst_n = 0; #2;
    push(0, 0, 0, 3'b010, 0, 0, 1); check("rst_mid");
    @(posedge clk); #1;
    rst_n = 1;
    idle(); rs_addr = 5; rt_addr = 3; alu_op = 3'b010; in_valid = 1;
    push(1, 0, 0, 3'b010, 0, 0, 1); cycle("gpr_cleared");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
